// File: rtl/axilite_mem_pkg.sv
// Shared types and address decode helper for the AXI-lite memory arbiter.
package axilite_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR      = 2'd1,
    ST_RD      = 2'd2,
    ST_RD_WAIT = 2'd3
  } state_t;

  typedef enum logic {
    RR_WR_LAST = 1'b0,
    RR_RD_LAST = 1'b1
  } rr_t;

  typedef struct packed {
    logic        in_win;
    logic [31:0] idx;
  } dec_t;

  function automatic int unsigned idx_width(input int unsigned range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

  // Widened to 64 bits so the window compare can never wrap at ADDR_W.
  function automatic dec_t decode_addr(input logic [63:0] addr,
                                       input logic [63:0] base,
                                       input int unsigned range,
                                       input int unsigned shift);
    logic [63:0] off;
    logic [63:0] widx;
    dec_t        d;
    off      = addr - base;
    widx     = off >> shift;
    d.in_win = (addr >= base) && (widx < 64'(range));
    d.idx    = widx[31:0];
    return d;
  endfunction

endpackage

// File: rtl/axilite_mem_arbiter_decode.sv
// Combinational window check and byte-address to word-index conversion.
module axilite_mem_decode
  import axilite_mem_pkg::*;
#(
  parameter int              ADDR_W         = 32,
  parameter int              DATA_W         = 64,
  parameter logic [ADDR_W-1:0] MEM_ADDR_START = 'h10000000,
  parameter int unsigned     MEM_ADDR_RANGE = 5,
  parameter int              IDX_W          = 3
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_in_win,
  output logic [IDX_W-1:0]  o_idx
);

  localparam int unsigned SHIFT = $clog2(DATA_W / 8);

  dec_t w_dec;

  assign w_dec    = decode_addr(64'(i_addr), 64'(MEM_ADDR_START), MEM_ADDR_RANGE, SHIFT);
  assign o_in_win = w_dec.in_win;
  assign o_idx    = IDX_W'(w_dec.idx);

endmodule

// File: rtl/axilite_mem_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between the
// write and read request channels of the AXI-lite slave.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for an eligible request; grant issues the access
// ST_WR      | write strobe on the memory port; sets w_ack on exit
// ST_RD      | read strobe on the memory port; loads latency counter
// ST_RD_WAIT | counts down RD_LAT, captures r_data and sets r_ack
module axilite_mem_arbiter
  import axilite_mem_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 64,
  parameter logic [ADDR_W-1:0] MEM_ADDR_START = 'h10000000,
  parameter int unsigned       MEM_ADDR_RANGE = 5,
  parameter int unsigned       RD_LAT         = 1,
  localparam int               IDX_W          = idx_width(MEM_ADDR_RANGE)
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                w_req,
  output logic                w_ack,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_strb,
  input  logic                r_req,
  output logic                r_ack,
  input  logic [ADDR_W-1:0]   r_addr,
  output logic [DATA_W-1:0]   r_data,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [IDX_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                oob
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  logic             w_wr_in_win;
  logic [IDX_W-1:0] w_wr_idx;
  logic             w_rd_in_win;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_wr_elig;
  logic             w_rd_elig;

  state_t           r_state;
  rr_t              r_rr;
  logic [CNT_W-1:0] r_cnt;

  axilite_mem_decode #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_ADDR_START(MEM_ADDR_START),
    .MEM_ADDR_RANGE(MEM_ADDR_RANGE), .IDX_W(IDX_W)
  ) u_wr_dec (
    .i_addr(w_addr), .o_in_win(w_wr_in_win), .o_idx(w_wr_idx)
  );

  axilite_mem_decode #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_ADDR_START(MEM_ADDR_START),
    .MEM_ADDR_RANGE(MEM_ADDR_RANGE), .IDX_W(IDX_W)
  ) u_rd_dec (
    .i_addr(r_addr), .o_in_win(w_rd_in_win), .o_idx(w_rd_idx)
  );

  // A channel still holding its ack is not re-serviced until req falls.
  assign w_wr_elig = w_req & ~w_ack;
  assign w_rd_elig = r_req & ~r_ack;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= ST_IDLE;
      r_rr      <= RR_RD_LAST;
      r_cnt     <= '0;
      w_ack     <= 1'b0;
      r_ack     <= 1'b0;
      r_data    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      oob       <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      oob    <= 1'b0;
      if (!w_req) w_ack <= 1'b0;
      if (!r_req) r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_wr_elig && (!w_rd_elig || r_rr == RR_RD_LAST)) begin
            r_rr      <= RR_WR_LAST;
            r_state   <= ST_WR;
            mem_en    <= w_wr_in_win;
            mem_we    <= 1'b1;
            mem_addr  <= w_wr_idx;
            mem_be    <= w_strb;
            mem_wdata <= w_data;
            oob       <= ~w_wr_in_win;
          end else if (w_rd_elig) begin
            r_rr     <= RR_RD_LAST;
            r_state  <= ST_RD;
            mem_en   <= w_rd_in_win;
            mem_we   <= 1'b0;
            mem_addr <= w_rd_idx;
          end
        end
        ST_WR: begin
          mem_we  <= 1'b0;
          w_ack   <= 1'b1;
          r_state <= ST_IDLE;
        end
        ST_RD: begin
          r_cnt   <= CNT_W'(RD_LAT);
          r_state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (r_cnt == CNT_W'(1)) begin
            r_data  <= w_rd_in_win ? mem_rdata : '0;
            oob     <= ~w_rd_in_win;
            r_ack   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axilite_mem_arbiter.sv
// Directed bench for axilite_mem_arbiter: one instance at RD_LAT=1 with a
// small memory model, one at RD_LAT=3 for latency and mid-read reset.
module tb_axilite_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int BW = DW / 8;
  localparam int IW = 3;

  logic aclk    = 1'b0;
  logic aresetn = 1'b1;
  always #5 aclk = ~aclk;

  logic          w_req = 1'b0, r_req = 1'b0;
  logic          w_ack, r_ack, mem_en, mem_we, oob;
  logic [AW-1:0] w_addr = '0, r_addr = '0;
  logic [DW-1:0] w_data = '0, r_data, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [BW-1:0] w_strb = '0, mem_be;
  logic [IW-1:0] mem_addr;

  logic          r3_req = 1'b0;
  logic          w3_ack, r3_ack, mem3_en, mem3_we, oob3;
  logic [AW-1:0] r3_addr = '0;
  logic [DW-1:0] r3_data, mem3_wdata;
  logic [BW-1:0] mem3_be;
  logic [IW-1:0] mem3_addr;
  logic [DW-1:0] mem3_rdata;
  assign mem3_rdata = 64'h00C0_FFEE;

  axilite_mem_arbiter u_dut (
    .aclk(aclk), .aresetn(aresetn),
    .w_req(w_req), .w_ack(w_ack), .w_addr(w_addr), .w_data(w_data), .w_strb(w_strb),
    .r_req(r_req), .r_ack(r_ack), .r_addr(r_addr), .r_data(r_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .oob(oob)
  );

  axilite_mem_arbiter #(.RD_LAT(3)) u_dut3 (
    .aclk(aclk), .aresetn(aresetn),
    .w_req(1'b0), .w_ack(w3_ack), .w_addr('0), .w_data('0), .w_strb('0),
    .r_req(r3_req), .r_ack(r3_ack), .r_addr(r3_addr), .r_data(r3_data),
    .mem_en(mem3_en), .mem_we(mem3_we), .mem_be(mem3_be), .mem_addr(mem3_addr),
    .mem_wdata(mem3_wdata), .mem_rdata(mem3_rdata), .oob(oob3)
  );

  // Single-port memory with one cycle of read latency.
  logic [DW-1:0] mem [8] = '{default: '0};
  int we_cnt = 0;
  always @(posedge aclk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < BW; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        we_cnt <= we_cnt + 1;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    w_req = 1'b0; r_req = 1'b0; r3_req = 1'b0;
    aresetn = 1'b0;
    tick(); tick();
    aresetn = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int we0;
    int seen;
    int lat;
    #1 aresetn = 1'b0;
    #2;
    chk("rst_w_ack", 64'(w_ack), 64'h0);
    chk("rst_r_ack", 64'(r_ack), 64'h0);
    chk("rst_mem_en", 64'(mem_en), 64'h0);
    chk("rst_mem_we", 64'(mem_we), 64'h0);
    chk("rst_oob", 64'(oob), 64'h0);
    chk("rst_r_data", 64'(r_data), 64'h0);
    chk("rst3_outs", 64'({w3_ack, r3_ack, mem3_en, mem3_we, oob3}), 64'h0);
    chk("rst3_bus", 64'(r3_data | mem3_wdata | 64'(mem3_be) | 64'(mem3_addr)), 64'h0);
    tick();
    aresetn = 1'b1;
    tick();

    // Write only
    w_req = 1'b1; w_addr = 32'h1000_0008; w_data = 64'hA5; w_strb = 8'hFF;
    tick();
    chk("wr_en", 64'(mem_en), 64'h1);
    chk("wr_we", 64'(mem_we), 64'h1);
    chk("wr_addr", 64'(mem_addr), 64'h1);
    chk("wr_wdata", 64'(mem_wdata), 64'hA5);
    chk("wr_be", 64'(mem_be), 64'hFF);
    chk("wr_ack_early", 64'(w_ack), 64'h0);
    tick();
    chk("wr_ack", 64'(w_ack), 64'h1);
    chk("wr_en_off", 64'(mem_en), 64'h0);
    repeat (3) tick();
    chk("wr_ack_held", 64'(w_ack), 64'h1);
    chk("wr_single", 64'(we_cnt), 64'h1);
    w_req = 1'b0;
    tick();
    chk("wr_ack_rel", 64'(w_ack), 64'h0);

    // Read back
    r_req = 1'b1; r_addr = 32'h1000_0008;
    tick();
    chk("rd_en", 64'(mem_en), 64'h1);
    chk("rd_we", 64'(mem_we), 64'h0);
    chk("rd_addr", 64'(mem_addr), 64'h1);
    tick();
    chk("rd_ack_early", 64'(r_ack), 64'h0);
    tick();
    chk("rd_ack", 64'(r_ack), 64'h1);
    chk("rd_data", 64'(r_data), 64'hA5);
    r_req = 1'b0;
    tick();
    chk("rd_ack_rel", 64'(r_ack), 64'h0);
    chk("rd_data_hold", 64'(r_data), 64'hA5);

    // Tie from reset: write wins, then read
    do_reset();
    w_req = 1'b1; w_addr = 32'h1000_0010; w_data = 64'h1111;
    r_req = 1'b1; r_addr = 32'h1000_0008;
    tick();
    chk("tie1_wr_en", 64'({mem_en, mem_we}), 64'h3);
    chk("tie1_wr_addr", 64'(mem_addr), 64'h2);
    tick();
    chk("tie1_w_ack", 64'(w_ack), 64'h1);
    tick();
    chk("tie1_rd_en", 64'({mem_en, mem_we}), 64'h2);
    chk("tie1_rd_addr", 64'(mem_addr), 64'h1);
    tick(); tick();
    chk("tie1_r_ack", 64'(r_ack), 64'h1);
    chk("tie1_r_data", 64'(r_data), 64'hA5);
    w_req = 1'b0; r_req = 1'b0;
    tick();

    // Last in-window word, leaves write as last grant
    w_req = 1'b1; w_addr = 32'h1000_0020; w_data = 64'h4444;
    tick();
    chk("edge_wr", 64'({mem_en, mem_we, oob}), 64'h6);
    chk("edge_addr", 64'(mem_addr), 64'h4);
    tick();
    chk("edge_w_ack", 64'(w_ack), 64'h1);
    w_req = 1'b0;
    tick();

    // Tie after a write grant: read wins
    w_req = 1'b1; w_addr = 32'h1000_0010;
    r_req = 1'b1; r_addr = 32'h1000_0020;
    tick();
    chk("tie2_rd_first", 64'({mem_en, mem_we}), 64'h2);
    chk("tie2_rd_addr", 64'(mem_addr), 64'h4);
    tick(); tick();
    chk("tie2_r_ack", 64'(r_ack), 64'h1);
    chk("tie2_r_data", 64'(r_data), 64'h4444);
    tick();
    chk("tie2_wr_second", 64'({mem_en, mem_we}), 64'h3);
    chk("tie2_wr_addr", 64'(mem_addr), 64'h2);
    tick();
    chk("tie2_w_ack", 64'(w_ack), 64'h1);
    w_req = 1'b0; r_req = 1'b0;
    tick();

    // Out-of-window read (idx 5) and write (below base)
    r_req = 1'b1; r_addr = 32'h1000_0028;
    tick();
    chk("oob_rd_no_en", 64'({mem_en, oob}), 64'h0);
    tick(); tick();
    chk("oob_rd_ack", 64'({r_ack, oob}), 64'h3);
    chk("oob_rd_data", 64'(r_data), 64'h0);
    tick();
    chk("oob_rd_pulse_end", 64'(oob), 64'h0);
    r_req = 1'b0;
    tick();
    we0 = we_cnt;
    w_req = 1'b1; w_addr = 32'h0FFF_FFF8; w_data = 64'hBAD;
    tick();
    chk("oob_wr_no_en", 64'({mem_en, oob}), 64'h1);
    tick();
    chk("oob_wr_ack", 64'({w_ack, oob}), 64'h2);
    chk("oob_wr_no_write", 64'(we_cnt - we0), 64'h0);
    w_req = 1'b0;
    tick();

    // Held write ack must not block a read nor re-execute the write
    we0 = we_cnt;
    w_req = 1'b1; w_addr = 32'h1000_0018; w_data = 64'h77;
    tick(); tick();
    chk("held_w_ack", 64'(w_ack), 64'h1);
    r_req = 1'b1; r_addr = 32'h1000_0018;
    tick();
    chk("held_rd_en", 64'({mem_en, mem_we}), 64'h2);
    tick(); tick();
    chk("held_r_ack", 64'(r_ack), 64'h1);
    chk("held_r_data", 64'(r_data), 64'h77);
    r_req = 1'b0;
    repeat (7) tick();
    chk("held_w_ack_still", 64'(w_ack), 64'h1);
    chk("held_single_we", 64'(we_cnt - we0), 64'h1);
    w_req = 1'b0;
    tick();
    chk("held_w_ack_rel", 64'(w_ack), 64'h0);

    // RD_LAT=3: full read, then reset during RD_WAIT
    do_reset();
    r3_req = 1'b1; r3_addr = 32'h1000_0008;
    tick();
    chk("r3_en", 64'(mem3_en), 64'h1);
    tick(); tick(); tick();
    chk("r3_ack_early", 64'(r3_ack), 64'h0);
    tick();
    chk("r3_ack", 64'(r3_ack), 64'h1);
    chk("r3_data", 64'(r3_data), 64'h00C0_FFEE);
    r3_req = 1'b0;
    tick();
    r3_req = 1'b1;
    tick(); tick();
    #2 aresetn = 1'b0;
    #1;
    chk("r3_rst_data", 64'(r3_data), 64'h0);
    chk("r3_rst_outs", 64'({r3_ack, mem3_en, oob3}), 64'h0);
    r3_req = 1'b0;
    tick();
    aresetn = 1'b1;
    seen = 0;
    repeat (8) begin
      tick();
      if (r3_ack || mem3_en) seen = 1;
    end
    chk("r3_no_ack_after_rst", 64'(seen), 64'h0);
    r3_req = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      tick();
      if (r3_ack) lat = i;
    end
    chk("r3_reissue_lat", 64'(lat), 64'h5);
    r3_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
